// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Four-channel push-button front end for the alarm clock keys. Each raw,
// asynchronous, bouncy button is synchronised, debounced and turned into a
// clean level plus one-cycle press (with optional hold auto-repeat) and
// release pulses.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           enable; low clears everything synchronously every cycle
//   btn_raw      raw active-high buttons, asynchronous to clk
//   btn_level    debounced level per channel (feeds encoder Y3..Y0)
//   btn_press    one-cycle pulse on accepted press and on every auto-repeat
//   btn_release  one-cycle pulse on accepted release
//   any_pressed  OR of all debounced levels
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 5000,
    parameter int REPEAT_PERIOD   = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic       any_pressed
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_V  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_V = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam bit               RPT_ON   = (REPEAT_DELAY != 0);

    logic [3:0]       s1;
    logic [3:0]       s2;
    state_t           state        [4];
    state_t           state_next   [4];
    logic [CNT_W-1:0] db_cnt       [4];
    logic [CNT_W-1:0] db_next      [4];
    logic [CNT_W-1:0] rpt_cnt      [4];
    logic [CNT_W-1:0] rpt_cnt_next [4];
    logic [CNT_W-1:0] rpt_lim      [4];
    logic [CNT_W-1:0] rpt_lim_next [4];
    logic [3:0]       press_next;
    logic [3:0]       release_next;
    logic [3:0]       accept;

    // The debounced level is simply the FSM state; a change is accepted on
    // the edge that would complete DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        btn_level = '0;
        accept    = '0;
        for (int i = 0; i < 4; i++) begin
            btn_level[i] = (state[i] == HELD);
            accept[i]    = (s2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    assign any_pressed = |btn_level;

    // Next-state logic per channel. A release takes priority over a repeat
    // so press and release can never pulse together on one channel.
    always_comb begin
        state_next   = state;
        db_next      = db_cnt;
        rpt_cnt_next = rpt_cnt;
        rpt_lim_next = rpt_lim;
        press_next   = '0;
        release_next = '0;
        for (int i = 0; i < 4; i++) begin
            if ((s2[i] == btn_level[i]) || accept[i]) begin
                db_next[i] = '0;
            end else begin
                db_next[i] = db_cnt[i] + ONE;
            end

            case (state[i])
                IDLE: begin
                    if (accept[i]) begin
                        state_next[i]   = HELD;
                        press_next[i]   = 1'b1;
                        rpt_cnt_next[i] = '0;
                        rpt_lim_next[i] = DELAY_V;
                    end
                end
                HELD: begin
                    if (accept[i]) begin
                        state_next[i]   = IDLE;
                        release_next[i] = 1'b1;
                        rpt_cnt_next[i] = '0;
                    end else if (RPT_ON) begin
                        if (rpt_cnt[i] == rpt_lim[i] - ONE) begin
                            press_next[i]   = 1'b1;
                            rpt_cnt_next[i] = '0;
                            rpt_lim_next[i] = PERIOD_V;
                        end else begin
                            rpt_cnt_next[i] = rpt_cnt[i] + ONE;
                        end
                    end
                end
                default: begin
                    state_next[i] = IDLE;
                end
            endcase
        end
    end

    // State registers. en low behaves like a synchronous reset, so partial
    // debounce counts are discarded and a held key must re-qualify.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i]   <= IDLE;
                db_cnt[i]  <= '0;
                rpt_cnt[i] <= '0;
                rpt_lim[i] <= '0;
            end
        end else if (!en) begin
            s1          <= '0;
            s2          <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i]   <= IDLE;
                db_cnt[i]  <= '0;
                rpt_cnt[i] <= '0;
                rpt_lim[i] <= '0;
            end
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            btn_press   <= press_next;
            btn_release <= release_next;
            for (int i = 0; i < 4; i++) begin
                state[i]   <= state_next[i];
                db_cnt[i]  <= db_next[i];
                rpt_cnt[i] <= rpt_cnt_next[i];
                rpt_lim[i] <= rpt_lim_next[i];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Drives two conditioners from the same inputs: dut_a with auto-repeat and
// dut_b with repeat disabled. A behavioural model predicts each cycle's
// outputs into a queue; a monitor pops and compares on the falling edge.
// Directed sequences hit the named scenarios, then randomised bouncy input
// with occasional en/reset drops follows.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] btn_raw;
    logic [3:0] a_level, a_press, a_rel;
    logic       a_any;
    logic [3:0] b_level, b_press, b_rel;
    logic       b_any;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .btn_raw(btn_raw),
        .btn_level(a_level), .btn_press(a_press), .btn_release(a_rel),
        .any_pressed(a_any)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .btn_raw(btn_raw),
        .btn_level(b_level), .btn_press(b_press), .btn_release(b_rel),
        .any_pressed(b_any)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic       any;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_pair_t;

    exp_pair_t sb_q[$];
    int tests = 0;
    int fails = 0;
    int press_a[4];
    int press_b[4];
    int rel_a[4];
    int rel_b[4];

    // Model state: index 0 models dut_a, index 1 models dut_b.
    bit m_s1   [2][4];
    bit m_s2   [2][4];
    bit m_level[2][4];
    int m_run  [2][4];
    int m_since[2][4];
    int m_gap  [2][4];
    int m_rd   [2];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] raw, input int cycles);
        btn_raw = raw;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Reference model: a change is taken once the delayed (synchronised)
    // sample has disagreed with the level for D consecutive edges; while held,
    // a press repeats after RD edges and then every RP edges.
    function automatic obs_t modelStep(input int k, input bit clear);
        obs_t o;
        bit   sampled;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            if (clear) begin
                m_s1[k][c] = 0; m_s2[k][c] = 0; m_level[k][c] = 0;
                m_run[k][c] = 0; m_since[k][c] = 0; m_gap[k][c] = 0;
            end else begin
                sampled    = m_s2[k][c];
                m_s2[k][c] = m_s1[k][c];
                m_s1[k][c] = btn_raw[c];
                m_run[k][c] = (sampled != m_level[k][c]) ? m_run[k][c] + 1 : 0;
                if (m_run[k][c] == D) begin
                    m_run[k][c]   = 0;
                    m_level[k][c] = !m_level[k][c];
                    if (m_level[k][c]) begin
                        o.press[c]    = 1'b1;
                        m_since[k][c] = 0;
                        m_gap[k][c]   = m_rd[k];
                    end else begin
                        o.rel[c] = 1'b1;
                    end
                end else if (m_level[k][c] && m_rd[k] != 0) begin
                    m_since[k][c]++;
                    if (m_since[k][c] == m_gap[k][c]) begin
                        o.press[c]    = 1'b1;
                        m_since[k][c] = 0;
                        m_gap[k][c]   = RP;
                    end
                end
            end
            o.level[c] = m_level[k][c];
        end
        o.any = |o.level;
        return o;
    endfunction

    // Predictor: one expected entry per rising edge, reset state while held.
    always @(posedge clk) begin : predictor
        exp_pair_t e;
        e.a = modelStep(0, !rst_n || !en);
        e.b = modelStep(1, !rst_n || !en);
        sb_q.push_back(e);
    end

    // Monitor: during reset outputs must be zero and pending predictions are
    // void; otherwise each falling edge consumes one prediction.
    always @(negedge clk) begin : monitor
        obs_t      act_a;
        obs_t      act_b;
        exp_pair_t e;
        act_a = {a_level, a_press, a_rel, a_any};
        act_b = {b_level, b_press, b_rel, b_any};
        for (int c = 0; c < 4; c++) begin
            press_a[c] += int'(a_press[c]);
            press_b[c] += int'(b_press[c]);
            rel_a[c]   += int'(a_rel[c]);
            rel_b[c]   += int'(b_rel[c]);
        end
        if (!rst_n) begin
            sb_q.delete();
            checkOutput("reset_a", 32'(act_a), 32'h0);
            checkOutput("reset_b", 32'(act_b), 32'h0);
        end else if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL sb_underflow at %0t: got empty queue expected an entry", $time);
        end else begin
            e = sb_q.pop_front();
            checkOutput("sb_a", 32'(act_a), 32'(e.a));
            checkOutput("sb_b", 32'(act_b), 32'(e.b));
        end
    end

    // Directed scenarios followed by randomised bouncy stimulus.
    initial begin
        int pa, pb, ra, rb, en_off, rst_off;
        bit target[4];
        m_rd[0] = RD;
        m_rd[1] = 0;
        for (int c = 0; c < 4; c++) begin
            press_a[c] = 0; press_b[c] = 0; rel_a[c] = 0; rel_b[c] = 0;
        end
        rst_n   = 1'b0;
        en      = 1'b1;
        btn_raw = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Short bursts on channel 0 never qualify.
        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0000, 2);
        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0000, 10);
        checkOutput("t1_level", 32'(a_level), 32'h0);
        checkOutput("t1_press_count", 32'(press_a[0]), 32'd0);

        // Channel 2 press lands on edge 6, then repeats at 16, 21, 26.
        applyStimulus(4'b0100, 5);
        checkOutput("t2_level_e5", 32'(a_level), 32'h0);
        applyStimulus(4'b0100, 1);
        checkOutput("t2_level_e6", 32'(a_level), 32'h4);
        checkOutput("t2_press_e6", 32'(a_press), 32'h4);
        applyStimulus(4'b0100, 1);
        checkOutput("t2_press_e7", 32'(a_press), 32'h0);
        applyStimulus(4'b0100, 8);
        checkOutput("t3_press_e15", 32'(a_press), 32'h0);
        applyStimulus(4'b0100, 1);
        checkOutput("t3_press_e16", 32'(a_press), 32'h4);
        applyStimulus(4'b0100, 4);
        checkOutput("t3_press_e20", 32'(a_press), 32'h0);
        applyStimulus(4'b0100, 1);
        checkOutput("t3_press_e21", 32'(a_press), 32'h4);
        applyStimulus(4'b0100, 5);
        checkOutput("t3_press_e26", 32'(a_press), 32'h4);
        applyStimulus(4'b0000, 5);
        checkOutput("t3_level_pre_release", 32'(a_level), 32'h4);
        checkOutput("t3_release_early", 32'(a_rel), 32'h0);
        applyStimulus(4'b0000, 1);
        checkOutput("t3_release", 32'(a_rel), 32'h4);
        checkOutput("t3_level_released", 32'(a_level), 32'h0);
        checkOutput("t3_press_at_release", 32'(a_press), 32'h0);
        applyStimulus(4'b0000, 3);

        // Simultaneous presses on channels 3 and 1.
        applyStimulus(4'b1010, 5);
        checkOutput("t4_level_e5", 32'(a_level), 32'h0);
        applyStimulus(4'b1010, 1);
        checkOutput("t4_level", 32'(a_level), 32'hA);
        checkOutput("t4_press", 32'(a_press), 32'hA);
        checkOutput("t4_any", 32'(a_any), 32'h1);
        applyStimulus(4'b0000, 8);

        // Reset while channel 3 is held and channel 0 is mid-count.
        applyStimulus(4'b1000, 8);
        checkOutput("t5_level_pre", 32'(a_level), 32'h8);
        applyStimulus(4'b1001, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_level_rst", 32'(a_level), 32'h0);
        checkOutput("t5_any_rst", 32'(a_any), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b1001, 5);
        checkOutput("t5_level_e5", 32'(a_level), 32'h0);
        applyStimulus(4'b1001, 1);
        checkOutput("t5_level_e6", 32'(a_level), 32'h9);
        checkOutput("t5_press_e6", 32'(a_press), 32'h9);
        applyStimulus(4'b0000, 8);

        // Long hold: dut_b pulses once, dut_a repeats; then en drops mid-hold.
        pa = press_a[1];
        pb = press_b[1];
        applyStimulus(4'b0010, 40);
        checkOutput("t6_b_press_count", 32'(press_b[1] - pb), 32'd1);
        checkOutput("t6_a_press_count", 32'(press_a[1] - pa), 32'd6);
        checkOutput("t6_b_level", 32'(b_level), 32'h2);
        ra = rel_a[1];
        rb = rel_b[1];
        en = 1'b0;
        applyStimulus(4'b0010, 1);
        checkOutput("t6_b_level_en0", 32'(b_level), 32'h0);
        checkOutput("t6_a_level_en0", 32'(a_level), 32'h0);
        checkOutput("t6_b_rel_en0", 32'(b_rel), 32'h0);
        applyStimulus(4'b0010, 3);
        checkOutput("t6_b_rel_count", 32'(rel_b[1] - rb), 32'd0);
        checkOutput("t6_a_rel_count", 32'(rel_a[1] - ra), 32'd0);
        en = 1'b1;
        applyStimulus(4'b0010, 5);
        checkOutput("t6_b_level_re5", 32'(b_level), 32'h0);
        applyStimulus(4'b0010, 1);
        checkOutput("t6_b_level_re6", 32'(b_level), 32'h2);
        checkOutput("t6_b_press_re6", 32'(b_press), 32'h2);
        applyStimulus(4'b0000, 8);

        // Random bouncy keys with rare en and reset drops.
        en_off  = 0;
        rst_off = 0;
        for (int c = 0; c < 4; c++) target[c] = 0;
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] r;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 29) == 0) target[c] = !target[c];
                r[c] = ($urandom_range(0, 5) == 0) ? !target[c] : target[c];
            end
            if (rst_off > 0) rst_off--;
            else if ($urandom_range(0, 299) == 0) rst_off = $urandom_range(1, 3);
            if (en_off > 0) en_off--;
            else if ($urandom_range(0, 199) == 0) en_off = $urandom_range(1, 5);
            rst_n = (rst_off == 0);
            en    = (en_off == 0);
            applyStimulus(r, 1);
        end

        rst_n = 1'b1;
        en    = 1'b1;
        applyStimulus(4'b0000, 12);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
